// File: rtl/calc_pkg.sv
// Shared definitions for the calc_seq accumulator block: operation codes in
// CombCalc encoding and the controller state encoding.
package calc_pkg;

   // Operation codes. The two abs operations only decode op[2:1], so the
   // LSB is a don't-care for them (01x = abs(B), 11x = abs(A)).
   localparam logic [2:0] OP_ADD  = 3'b000;  // A + B
   localparam logic [2:0] OP_SUB  = 3'b001;  // A - B
   localparam logic [2:0] OP_ABSB = 3'b010;  // abs(B)
   localparam logic [2:0] OP_RADD = 3'b100;  // B + A
   localparam logic [2:0] OP_RSUB = 3'b101;  // B - A
   localparam logic [2:0] OP_ABSA = 3'b110;  // abs(A)

   // Controller state enumeration, kept as plain constants so the state
   // register stays a bare vector for legacy tooling.
   typedef logic [1:0] state_t;
   localparam state_t ST_IDLE = 2'd0;
   localparam state_t ST_EXEC = 2'd1;
   localparam state_t ST_DONE = 2'd2;

   // True when the code selects one of the abs operations on the given
   // operand (compares the decoded upper bits only).
   function automatic logic is_abs_of(input logic [2:0] op, input logic [2:0] abs_code);
      return op[2:1] == abs_code[2:1];
   endfunction

endpackage

// File: rtl/comb_calc.sv
// CombCalc: purely combinational W-bit two's-complement ALU with overflow.
// Optional feature: define CALC_SAT_EN to saturate results that overflow.
module comb_calc
   import calc_pkg::*;
#(
   parameter int W = 16
) (
   input  logic [2:0]         op,
   input  logic               ld,
   input  logic signed [W-1:0] a,
   input  logic signed [W-1:0] b,
   output logic signed [W-1:0] r,
   output logic               ovf
);

   localparam logic signed [W-1:0] MAX_V = {1'b0, {(W-1){1'b1}}};
   localparam logic signed [W-1:0] MIN_V = {1'b1, {(W-1){1'b0}}};

   logic signed [W-1:0] sum_ab;
   logic signed [W-1:0] diff_ab;
   logic signed [W-1:0] diff_ba;
   logic signed [W-1:0] neg_a;
   logic signed [W-1:0] neg_b;
   logic signed [W-1:0] raw_r;
   logic                raw_ovf;

   // All candidate results in parallel; each wraps modulo 2^W.
   always_comb begin
      sum_ab  = a + b;
      diff_ab = a - b;
      diff_ba = b - a;
      neg_a   = -a;
      neg_b   = -b;
   end

   // Operation select and signed-overflow detection. Addition overflows when
   // both operands share a sign the result lacks; subtraction when operand
   // signs differ and the result sign departs from the minuend; abs only
   // overflows on the most negative value, which negates to itself.
   always_comb begin
      // NOTE: every output of a combinational block gets a default first so no
      // path can leave it unassigned and infer a latch.
      raw_r   = '0;
      raw_ovf = 1'b0;
      if (ld) begin
         raw_r   = b;
         raw_ovf = 1'b0;
      end else if (is_abs_of(op, OP_ABSB)) begin
         raw_r   = b[W-1] ? neg_b : b;
         raw_ovf = (b == MIN_V);
      end else if (is_abs_of(op, OP_ABSA)) begin
         raw_r   = a[W-1] ? neg_a : a;
         raw_ovf = (a == MIN_V);
      end else begin
         case (op)
            OP_ADD, OP_RADD: begin
               raw_r   = sum_ab;
               raw_ovf = (a[W-1] == b[W-1]) && (sum_ab[W-1] != a[W-1]);
            end
            OP_SUB: begin
               raw_r   = diff_ab;
               raw_ovf = (a[W-1] != b[W-1]) && (diff_ab[W-1] != a[W-1]);
            end
            OP_RSUB: begin
               raw_r   = diff_ba;
               raw_ovf = (a[W-1] != b[W-1]) && (diff_ba[W-1] != b[W-1]);
            end
            default: begin
               raw_r   = '0;
               raw_ovf = 1'b0;
            end
         endcase
      end
   end

   // Result shaping: saturate on overflow when enabled, otherwise pass the
   // wrapped value. A wrapped negative means the true value ran off the top.
   always_comb begin
      ovf = raw_ovf;
`ifdef CALC_SAT_EN
      if (raw_ovf) begin
         r = raw_r[W-1] ? MAX_V : MIN_V;
      end else begin
         r = raw_r;
      end
`else
      r = raw_r;
`endif
   end

endmodule

// File: rtl/calc_seq.sv
// calc_seq: handshaked accumulator. A command (op/ld/b_in) is accepted,
// executed against the accumulator one cycle later, and the registered
// result is held until consumed. Optional saturation via CALC_SAT_EN
// (implemented inside comb_calc).
module calc_seq
   import calc_pkg::*;
#(
   parameter int W = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [2:0]         op,
   input  logic               ld,
   input  logic signed [W-1:0] b_in,
   input  logic               clr_ovf,
   output logic               out_valid,
   input  logic               out_ready,
   output logic signed [W-1:0] res,
   output logic               res_ovf,
   output logic               ovf_sticky
);

   state_t              state_q, state_d;
   logic [2:0]          op_q, op_d;
   logic                ld_q, ld_d;
   logic signed [W-1:0] b_q, b_d;
   logic signed [W-1:0] acc_q, acc_d;
   logic signed [W-1:0] res_q, res_d;
   logic                res_ovf_q, res_ovf_d;
   logic                out_valid_q, out_valid_d;
   logic                ovf_sticky_q, ovf_sticky_d;

   logic signed [W-1:0] calc_r;
   logic                calc_ovf;
   logic                accept;
   logic                sticky_set;
   logic                sticky_clr;

   // The datapath always sees the accumulator and the captured operand; its
   // output is only used on the EXEC edge.
   comb_calc #(.W(W)) u_comb_calc (
      .op  (op_q),
      .ld  (ld_q),
      .a   (acc_q),
      .b   (b_q),
      .r   (calc_r),
      .ovf (calc_ovf)
   );

   // Ready when idle, or when the held result is being consumed this cycle so
   // a new command can follow without a bubble.
   always_comb begin
      in_ready = (state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready);
      accept   = in_valid && in_ready;
   end

   // Controller and datapath next-state.
   always_comb begin
      state_d     = state_q;
      op_d        = op_q;
      ld_d        = ld_q;
      b_d         = b_q;
      acc_d       = acc_q;
      res_d       = res_q;
      res_ovf_d   = res_ovf_q;
      out_valid_d = out_valid_q;

      if (accept) begin
         op_d = op;
         ld_d = ld;
         b_d  = b_in;
      end

      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               state_d = ST_EXEC;
            end
         end
         ST_EXEC: begin
            acc_d       = calc_r;
            res_d       = calc_r;
            res_ovf_d   = calc_ovf;
            out_valid_d = 1'b1;
            state_d     = ST_DONE;
         end
         ST_DONE: begin
            // Result is frozen until the consumer takes it.
            if (out_ready) begin
               out_valid_d = 1'b0;
               state_d     = accept ? ST_EXEC : ST_IDLE;
            end
         end
         default: begin
            state_d     = ST_IDLE;
            out_valid_d = 1'b0;
         end
      endcase
   end

   // Sticky overflow: set by an overflowing execution, cleared by clr_ovf or
   // by an accepted load; a coincident set wins over the clear.
   always_comb begin
      sticky_set = (state_q == ST_EXEC) && calc_ovf;
      sticky_clr = clr_ovf || (accept && ld);
      if (sticky_set) begin
         ovf_sticky_d = 1'b1;
      end else if (sticky_clr) begin
         ovf_sticky_d = 1'b0;
      end else begin
         ovf_sticky_d = ovf_sticky_q;
      end
   end

   // State registers; reset takes effect immediately regardless of state.
   always_ff @(posedge clk or posedge rst) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values, independent of statement order.
      if (rst) begin
         state_q      <= ST_IDLE;
         op_q         <= '0;
         ld_q         <= 1'b0;
         b_q          <= '0;
         acc_q        <= '0;
         res_q        <= '0;
         res_ovf_q    <= 1'b0;
         out_valid_q  <= 1'b0;
         ovf_sticky_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         op_q         <= op_d;
         ld_q         <= ld_d;
         b_q          <= b_d;
         acc_q        <= acc_d;
         res_q        <= res_d;
         res_ovf_q    <= res_ovf_d;
         out_valid_q  <= out_valid_d;
         ovf_sticky_q <= ovf_sticky_d;
      end
   end

   assign out_valid  = out_valid_q;
   assign res        = res_q;
   assign res_ovf    = res_ovf_q;
   assign ovf_sticky = ovf_sticky_q;

endmodule

// File: tb/tb_calc_seq.sv
// Self-checking bench for calc_seq. The reference model computes each result
// with wide integer arithmetic and folds it back into W bits.
module tb_calc_seq;

   localparam int W    = 16;
   localparam int MAXV = (1 << (W - 1)) - 1;
   localparam int MINV = -(1 << (W - 1));

   logic               clk = 1'b0;
   logic               rst = 1'b1;
   logic               in_valid = 1'b0;
   logic               in_ready;
   logic [2:0]         op = 3'd0;
   logic               ld = 1'b0;
   logic signed [W-1:0] b_in = '0;
   logic               clr_ovf = 1'b0;
   logic               out_valid;
   logic               out_ready = 1'b0;
   logic signed [W-1:0] res;
   logic               res_ovf;
   logic               ovf_sticky;

   int checks = 0;
   int errors = 0;

   // Model state
   int acc_m     = 0;
   bit sticky_m  = 1'b0;
   bit in_done   = 1'b0;
   int res_m     = 0;
   bit res_ovf_m = 1'b0;

   calc_seq #(.W(W)) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .op         (op),
      .ld         (ld),
      .b_in       (b_in),
      .clr_ovf    (clr_ovf),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .res        (res),
      .res_ovf    (res_ovf),
      .ovf_sticky (ovf_sticky)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   // Reference: exact result from the operation rules, then wrap to W bits.
   function automatic void ref_calc(input bit l, input logic [2:0] o, input int a, input int b,
                                    output int r, output bit v);
      longint t;
      if (l) t = b;
      else begin
         case (o)
            3'd0, 3'd4: t = longint'(a) + longint'(b);
            3'd1:       t = longint'(a) - longint'(b);
            3'd5:       t = longint'(b) - longint'(a);
            3'd2, 3'd3: t = (b < 0) ? -longint'(b) : longint'(b);
            default:    t = (a < 0) ? -longint'(a) : longint'(a);
         endcase
      end
      v = !l && (t > MAXV || t < MINV);
      while (t > MAXV) t = t - (longint'(1) << W);
      while (t < MINV) t = t + (longint'(1) << W);
      r = int'(t);
`ifdef CALC_SAT_EN
      if (v) r = (r < 0) ? MAXV : MINV;
`endif
   endfunction

   // Issue one command (consuming any held result on the same edge), then
   // check the EXEC cycle and the result two edges after accept.
   task automatic run_cmd(input string name, input bit l, input logic [2:0] o, input int b,
                          input bit clr, input bit clr_hold);
      int  r_exp;
      bit  v_exp;
      logic signed [W-1:0] r_vec;
      in_valid  = 1'b1;
      ld        = l;
      op        = o;
      b_in      = b[W-1:0];
      out_ready = in_done;
      clr_ovf   = clr;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL %s in_ready before accept: got %b want 1", name, in_ready);
      end
      @(posedge clk); #1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      clr_ovf   = clr_hold;
      if (l || clr) sticky_m = 1'b0;
      ref_calc(l, o, acc_m, b, r_exp, v_exp);
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL %s out_valid one edge after accept: got %b want 0", name, out_valid);
      end
      checks++;
      if (ovf_sticky !== sticky_m) begin
         errors++;
         $display("FAIL %s ovf_sticky after accept: got %b want %b", name, ovf_sticky, sticky_m);
      end
      @(posedge clk); #1;
      clr_ovf = 1'b0;
      if (v_exp) sticky_m = 1'b1;
      else if (clr_hold) sticky_m = 1'b0;
      acc_m     = r_exp;
      res_m     = r_exp;
      res_ovf_m = v_exp;
      in_done   = 1'b1;
      r_vec     = r_exp[W-1:0];
      checks++;
      if (out_valid !== 1'b1) begin
         errors++;
         $display("FAIL %s out_valid two edges after accept: got %b want 1", name, out_valid);
      end
      checks++;
      if (res !== r_vec) begin
         errors++;
         $display("FAIL %s res: got %0d want %0d", name, res, r_vec);
      end
      checks++;
      if (res_ovf !== v_exp) begin
         errors++;
         $display("FAIL %s res_ovf: got %b want %b", name, res_ovf, v_exp);
      end
      checks++;
      if (ovf_sticky !== sticky_m) begin
         errors++;
         $display("FAIL %s ovf_sticky: got %b want %b", name, ovf_sticky, sticky_m);
      end
   endtask

   // Consume the held result without issuing a new command.
   task automatic consume(input string name);
      out_ready = 1'b1;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL %s in_ready while consuming: got %b want 1", name, in_ready);
      end
      @(posedge clk); #1;
      out_ready = 1'b0;
      in_done   = 1'b0;
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL %s out_valid after consume: got %b want 0", name, out_valid);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b0 || res !== '0 || res_ovf !== 1'b0 || ovf_sticky !== 1'b0) begin
         errors++;
         $display("FAIL reset outputs: got v=%b r=%0d o=%b s=%b want all 0",
                  out_valid, res, res_ovf, ovf_sticky);
      end
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset in_ready: got %b want 1", in_ready);
      end
   endtask

   task automatic test_basic();
      run_cmd("ld100", 1'b1, 3'd0, 100, 1'b0, 1'b0);
      consume("ld100");
      run_cmd("add5", 1'b0, 3'd0, 5, 1'b0, 1'b0);
      checks++;
      if (res !== 16'sd105 || res_ovf !== 1'b0) begin
         errors++;
         $display("FAIL add5 literal: got %0d/%b want 105/0", res, res_ovf);
      end
      consume("add5");
   endtask

   task automatic test_overflow();
      logic signed [W-1:0] want;
      run_cmd("ld32760", 1'b1, 3'd0, 32760, 1'b0, 1'b0);
      consume("ld32760");
      run_cmd("add100", 1'b0, 3'd0, 100, 1'b0, 1'b0);
`ifdef CALC_SAT_EN
      want = 16'sd32767;
`else
      want = -16'sd32676;
`endif
      checks++;
      if (res !== want || res_ovf !== 1'b1 || ovf_sticky !== 1'b1) begin
         errors++;
         $display("FAIL add100 literal: got %0d/%b/%b want %0d/1/1", res, res_ovf, ovf_sticky, want);
      end
      consume("add100");
      // clr_ovf alone clears the sticky flag
      clr_ovf = 1'b1;
      @(posedge clk); #1;
      clr_ovf  = 1'b0;
      sticky_m = 1'b0;
      checks++;
      if (ovf_sticky !== 1'b0) begin
         errors++;
         $display("FAIL clr_ovf: got %b want 0", ovf_sticky);
      end
      // re-arm, then an accepted load clears it
      run_cmd("abs_min_ld", 1'b1, 3'd0, MINV, 1'b0, 1'b0);
      run_cmd("abs_min", 1'b0, 3'd6, 0, 1'b0, 1'b0);
      run_cmd("ld_clears", 1'b1, 3'd0, 32767, 1'b0, 1'b0);
      // set coincides with clear: set wins
      run_cmd("set_wins", 1'b0, 3'd0, 1, 1'b1, 1'b1);
      checks++;
      if (ovf_sticky !== 1'b1) begin
         errors++;
         $display("FAIL set_wins literal: got %b want 1", ovf_sticky);
      end
      consume("set_wins");
   endtask

   task automatic test_reverse_abs();
      run_cmd("ld-50", 1'b1, 3'd0, -50, 1'b0, 1'b0);
      run_cmd("rsub20", 1'b0, 3'd5, 20, 1'b0, 1'b0);
      checks++;
      if (res !== 16'sd70) begin
         errors++;
         $display("FAIL rsub20 literal: got %0d want 70", res);
      end
      run_cmd("ld-45", 1'b1, 3'd0, -45, 1'b0, 1'b0);
      run_cmd("absa", 1'b0, 3'd6, 999, 1'b0, 1'b0);
      checks++;
      if (res !== 16'sd45) begin
         errors++;
         $display("FAIL absa literal: got %0d want 45", res);
      end
      run_cmd("absb", 1'b0, 3'd3, -1234, 1'b0, 1'b0);
      run_cmd("sub", 1'b0, 3'd1, 2000, 1'b0, 1'b0);
      run_cmd("radd", 1'b0, 3'd4, -7, 1'b0, 1'b0);
      consume("radd");
   endtask

   task automatic test_hold();
      logic signed [W-1:0] held;
      run_cmd("hold_cmd", 1'b0, 3'd1, 3, 1'b0, 1'b0);
      held      = res_m[W-1:0];
      in_valid  = 1'b1;
      ld        = 1'b1;
      b_in      = 16'sd1234;
      out_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         #1;
         checks++;
         if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL hold in_ready cycle %0d: got %b want 0", i, in_ready);
         end
         @(posedge clk); #1;
         checks++;
         if (out_valid !== 1'b1 || res !== held || res_ovf !== res_ovf_m) begin
            errors++;
            $display("FAIL hold cycle %0d: got v=%b r=%0d want v=1 r=%0d", i, out_valid, res, held);
         end
      end
      in_valid = 1'b0;
      ld       = 1'b0;
      consume("hold");
   endtask

   task automatic test_back_to_back();
      run_cmd("b2b_first", 1'b1, 3'd0, 300, 1'b0, 1'b0);
      run_cmd("b2b_second", 1'b0, 3'd0, 11, 1'b0, 1'b0);
      run_cmd("b2b_third", 1'b0, 3'd5, 1000, 1'b0, 1'b0);
      checks++;
      if (res !== 16'sd689) begin
         errors++;
         $display("FAIL b2b literal: got %0d want 689", res);
      end
      consume("b2b");
   endtask

   task automatic test_rst_exec();
      run_cmd("pre_rst", 1'b1, 3'd0, MAXV, 1'b0, 1'b0);
      // accept an overflowing add so sticky is set, then reset mid-EXEC
      run_cmd("pre_rst_ovf", 1'b0, 3'd0, 10, 1'b0, 1'b0);
      out_ready = 1'b1;
      in_valid  = 1'b1;
      ld        = 1'b0;
      op        = 3'd0;
      b_in      = 16'sd9;
      @(posedge clk); #1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      rst       = 1'b1;
      #1;
      checks++;
      if (out_valid !== 1'b0 || res !== '0 || res_ovf !== 1'b0 || ovf_sticky !== 1'b0) begin
         errors++;
         $display("FAIL rst_exec outputs: got v=%b r=%0d o=%b s=%b want all 0",
                  out_valid, res, res_ovf, ovf_sticky);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      #1;
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL rst_exec release: got rdy=%b v=%b want 1/0", in_ready, out_valid);
      end
      acc_m    = 0;
      sticky_m = 1'b0;
      in_done  = 1'b0;
      // accumulator must have restarted from zero
      run_cmd("post_rst_add", 1'b0, 3'd0, 7, 1'b0, 1'b0);
      checks++;
      if (res !== 16'sd7) begin
         errors++;
         $display("FAIL post_rst literal: got %0d want 7", res);
      end
      // reset while holding in DONE
      rst = 1'b1;
      #1;
      checks++;
      if (out_valid !== 1'b0 || res !== '0) begin
         errors++;
         $display("FAIL rst_done outputs: got v=%b r=%0d want 0/0", out_valid, res);
      end
      @(posedge clk); #1;
      rst      = 1'b0;
      acc_m    = 0;
      sticky_m = 1'b0;
      in_done  = 1'b0;
   endtask

   task automatic test_random();
      int b;
      int sel;
      bit l;
      for (int n = 0; n < 150; n++) begin
         sel = int'($urandom_range(0, 9));
         case (sel)
            0: b = MAXV;
            1: b = MINV;
            2: b = -1;
            3: b = 1;
            default: b = int'($urandom_range(0, 65535)) - 32768;
         endcase
         l = ($urandom_range(0, 4) == 0);
         if (in_done && $urandom_range(0, 1) == 0) begin
            repeat ($urandom_range(0, 2)) begin
               @(posedge clk); #1;
               checks++;
               if (out_valid !== 1'b1 || res !== res_m[W-1:0]) begin
                  errors++;
                  $display("FAIL rand hold %0d: got v=%b r=%0d want 1/%0d", n, out_valid, res, res_m);
               end
            end
            consume("rand");
         end
         run_cmd("rand", l, 3'($urandom_range(0, 7)), b,
                 ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0));
      end
      consume("rand_end");
   endtask

   initial begin
      test_reset();
      test_basic();
      test_overflow();
      test_reverse_abs();
      test_hold();
      test_back_to_back();
      test_rst_exec();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/calc_seq.md
CALC_SEQ -- requirements
Module: calc_seq

Interface
REQ-001 SHALL have parameter W, default 16, meaning signed operand/accumulator/result width in bits.
REQ-002 SHALL have port clk, input, 1, the single rising-edge clock.
REQ-003 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port in_valid, input, 1, command present.
REQ-005 SHALL have port in_ready, output, 1, command accepted when in_valid && in_ready at a clk edge.
REQ-006 SHALL have port op, input, 3, operation code in CombCalc encoding.
REQ-007 SHALL have port ld, input, 1, load command: acc <= b_in and op is ignored.
REQ-008 SHALL have port b_in, input, W signed, B operand.
REQ-009 SHALL have port clr_ovf, input, 1, synchronous clear of ovf_sticky.
REQ-010 SHALL have port out_valid, output, 1, result present.
REQ-011 SHALL have port out_ready, input, 1, result consumed when out_valid && out_ready at a clk edge.
REQ-012 SHALL have port res, output, W signed, registered result.
REQ-013 SHALL have port res_ovf, output, 1, overflow flag of the current result.
REQ-014 SHALL have port ovf_sticky, output, 1, accumulated overflow flag.

Function
REQ-015 SHALL use a three-state FSM: IDLE, EXEC, DONE.
REQ-016 SHALL drive in_ready = (state==IDLE) || (state==DONE && out_ready).
REQ-017 On accept, SHALL register op, ld and b_in, and SHALL enter EXEC.
REQ-018 In EXEC, SHALL drive CombCalc with A = acc and B = registered b.
REQ-019 Ops: 000 A+B; 001 A-B; 01x abs(B); 100 B+A; 101 B-A; 11x abs(A).
REQ-020 At the EXEC edge, SHALL set acc <= res <= result, set res_ovf <= ovf, set out_valid <= 1, and enter DONE.
REQ-021 Result SHALL be out_valid at the second edge after accept, giving a latency of 2 cycles.
REQ-022 For a load command, SHALL set result = registered b with ovf = 0.
REQ-023 In DONE, SHALL hold res, res_ovf and out_valid stable until the output handshake occurs.
REQ-024 When the output handshake occurs without in_valid, SHALL clear out_valid and enter IDLE.
REQ-025 When the output handshake and input accept occur on the same edge, SHALL clear out_valid and enter EXEC with the new command.
REQ-026 SHALL set ovf_sticky when the EXEC edge has ovf=1.
REQ-027 SHALL clear ovf_sticky on clr_ovf or on an accepted ld.
REQ-028 When a set and a clear of ovf_sticky coincide, the set SHALL win.
REQ-029 Arithmetic SHALL be two's-complement W-bit wrap, including abs(-2^(W-1)) = -2^(W-1) with ovf=1.

Reset
REQ-030 rst SHALL immediately force state=IDLE, acc=0, res=0, res_ovf=0, out_valid=0, ovf_sticky=0, and operand registers=0, including when rst arrives mid-EXEC or mid-DONE.
REQ-031 in_ready SHALL be 1 whenever rst is deasserted and state is IDLE.

Configuration
REQ-032 With CALC_SAT_EN defined, SHALL replace the result on ovf=1 with 2^(W-1)-1 if R[W-1]=1, else -2^(W-1), and SHALL still assert res_ovf and ovf_sticky.
REQ-033 Without CALC_SAT_EN, SHALL pass the wrapped result unchanged.

Structure
REQ-034 calc_pkg SHALL hold the op encodings (OP_ADD, OP_SUB, OP_ABSB, OP_RADD, OP_RSUB, OP_ABSA) and the state enum.
REQ-035 SHALL instantiate exactly one CombCalc sub-module with .W(W).
REQ-036 All outputs except in_ready SHALL be registered.

Verification
REQ-037 Bench SHALL check: reset; ld b_in=100; op=000 b_in=5 -> res=105, res_ovf=0, out_valid two edges after accept.
REQ-038 Bench SHALL check: acc=32760; op=000 b_in=100 -> res=-32676, res_ovf=1, ovf_sticky=1; with CALC_SAT_EN res=32767.
REQ-039 Bench SHALL check: acc=-50; op=101 b_in=20 -> res=70; then op=110 with acc=-45 -> res=45.
REQ-040 Bench SHALL check: out_ready=0 for 5 cycles in DONE -> out_valid=1, res stable, in_ready=0 throughout.
REQ-041 Bench SHALL check: in DONE, out_ready=1 and in_valid=1 on the same edge -> new command accepted, next out_valid two edges later.
REQ-042 Bench SHALL check: rst pulse during EXEC -> all outputs 0, state IDLE, in_ready=1 after release.
